// File: rtl/eeprom_spi_slave_pkg.sv
// rtl/eeprom_spi_slave_pkg.sv - shared opcode, frame and state definitions for the EEPROM SPI slave
// Contents: eep_op_t (frame opcodes, shared with the dispatcher's SPI master),
//           FRAME_BITS (legal frame length), eep_state_t (slave frame FSM states).
package eeprom_spi_pkg;

  typedef enum logic [1:0] {
    EEP_READ  = 2'b00,
    EEP_WRITE = 2'b01
  } eep_op_t;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT,
    DECODE
  } eep_state_t;

endpackage

// File: rtl/eeprom_spi_slave_if.sv
// rtl/eeprom_spi_slave_if.sv - SPI pin bundle between the dispatcher's master and the EEPROM slave
// Signals: SS_n (slave select, active low), SCLK (mode 0 clock, idle low),
//          MOSI (master to slave data), MISO (slave to master data).
// Modports: master drives SS_n/SCLK/MOSI, slave drives MISO.
interface eeprom_spi_if;

  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/eeprom_spi_slave_pin_sync.sv
// rtl/eeprom_spi_slave_pin_sync.sv - 2-flop synchronizer plus history flop with edge pulses
// Ports: clk, rst_n (sync, active low), pin (asynchronous input),
//        lvl (synchronized level), rise / fall (one-clk edge pulses, aligned with lvl).
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  // sync_q[0..1] synchronize, sync_q[2] holds the previous synchronized level.
  // Reset to 0 so a select line held low through reset never yields a fall edge.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], pin};
    end
  end

  assign lvl  = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/eeprom_spi_slave.sv
// rtl/eeprom_spi_slave.sv - SPI mode 0 slave serving 16-bit read/write frames on a 64x8 calibration store
// Ports: clk, rst_n (sync, active low), spi (eeprom_spi_if.slave: SS_n, SCLK, MOSI in; MISO out),
//        frame_done (pulse: legal 16-bit frame executed), frame_err (pulse: frame with wrong bit count).
module eeprom_spi_slave
  import eeprom_spi_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  eeprom_spi_if.slave spi,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] SAT_CNT  = 5'(FRAME_BITS + 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  // Identical synchronizer depth keeps MOSI aligned with the SCLK edges.
  spi_pin_sync u_sync_ss (
    .clk (clk), .rst_n (rst_n), .pin (spi.SS_n),
    .lvl (ss_lvl), .rise (ss_rise), .fall (ss_fall)
  );

  spi_pin_sync u_sync_sclk (
    .clk (clk), .rst_n (rst_n), .pin (spi.SCLK),
    .lvl (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_pin_sync u_sync_mosi (
    .clk (clk), .rst_n (rst_n), .pin (spi.MOSI),
    .lvl (mosi_lvl), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
  );

  eep_state_t                state_q, state_d;
  logic [FRAME_BITS-1:0]     rx_shift, tx_shift;
  logic [4:0]                bit_cnt;
  logic [DATA_W-1:0]         rd_buf;
  logic [DATA_W-1:0]         mem [2**ADDR_W];

  logic                      load_tx;
  logic                      exec;
  logic [1:0]                frame_op;
  logic [ADDR_W-1:0]         frame_addr;
  logic [DATA_W-1:0]         frame_data;

  assign frame_op   = rx_shift[FRAME_BITS-1 -: 2];
  assign frame_addr = rx_shift[DATA_W +: ADDR_W];
  assign frame_data = rx_shift[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_tx    = 1'b0;
    exec       = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      // A frame already running when reset released must not be decoded.
      WAIT_HI: if (ss_lvl) state_d = IDLE;
      IDLE: begin
        if (ss_fall) begin
          load_tx = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: if (ss_rise) state_d = DECODE;
      DECODE: begin
        if (bit_cnt == FULL_CNT) begin
          exec       = 1'b1;
          frame_done = 1'b1;
        end else begin
          frame_err  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
      rd_buf   <= '0;
    end else begin
      if (load_tx) begin
        // Response carries the data of the most recent prior READ.
        tx_shift <= {{(FRAME_BITS-DATA_W){1'b0}}, rd_buf};
        bit_cnt  <= '0;
      end
      if (state_q == SHIFT) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_lvl};
          if (bit_cnt != SAT_CNT) bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_fall) begin
          tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
        end
      end
      if (exec && frame_op == EEP_READ) begin
        rd_buf <= mem[frame_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (exec && frame_op == EEP_WRITE) begin
      mem[frame_addr] <= frame_data;
    end
  end

  assign spi.MISO = ss_lvl ? 1'b0 : tx_shift[FRAME_BITS-1];

endmodule

// File: doc/eeprom_spi_slave.md
# eeprom_spi_slave

SPI slave that answers the 16-bit EEPROM frames issued by the command dispatcher's SPI master. It holds the 64×8 calibration store, which contains the offset and gain entries addressed by channel and gain index. It executes read and write frames and returns read data in the frame that follows the read. It sits on the EEPROM slave-select line and serves as the RTL EEPROM for system simulation and for the FPGA build.

## Interface
- ADDR_W, 6: EEPROM address width; store depth is 2**ADDR_W.
- DATA_W, 8: data width.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- SS_n  in  1  slave select, active low, asynchronous to clk.
- SCLK  in  1  SPI clock, asynchronous to clk, idle low.
- MOSI  in  1  master out, slave in.
- MISO  out  1  slave out, master in. Reset value 0.
- frame_done  out  1  one-cycle pulse when a legal 16-bit frame is decoded. Reset value 0.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than 16. Reset value 0.

## Operation
- Frame format, MSB first: [15:14] opcode, [13:8] address, [7:0] write data.
- Opcode 2'b00 READ: rd_buf <= mem[addr].
- Opcode 2'b01 WRITE: mem[addr] <= data.
- Opcodes 2'b10 and 2'b11 are reserved: no effect on mem or rd_buf, and frame_done still pulses.
- SPI mode 0:
  - MOSI is sampled on the SCLK rise.
  - MISO is updated on the SCLK fall.
  - MISO is valid from the SS_n fall.
- Response word {8'h00, rd_buf} is loaded into tx_shift on the SS_n fall. Every frame returns the rd_buf value set by the most recent prior READ, whatever the current frame's opcode.
- A READ therefore needs a following frame to carry its data out; the master issues a dummy frame for this.
- Reset clears:
  - all mem entries to 8'h00
  - rd_buf to 8'h00
  - tx_shift to 0
  - rx_shift to 0
  - bit_cnt to 0
- State machine:
  - WAIT_HI (reset state): go to IDLE when synced SS_n = 1. This prevents a frame already in progress at reset from being decoded.
  - IDLE: on the SS_n fall, load tx_shift, clear bit_cnt, go to SHIFT.
  - SHIFT: on each SCLK rise, shift MOSI into rx_shift and increment bit_cnt (5 bits, saturating at 17). On each SCLK fall, shift tx_shift left. On the SS_n rise, go to DECODE.
  - DECODE (one cycle): if bit_cnt == 16, execute the frame and pulse frame_done. Otherwise pulse frame_err and leave mem and rd_buf untouched. Then go to IDLE.
- MISO = tx_shift[15] while SS_n is low, 0 otherwise.
- SCLK edges seen while SS_n is high are ignored.

## Timing
- SS_n, SCLK and MOSI pass through identical 2-flop synchronizers plus one history flop. Edges are detected 2–3 clk after the pin changes, and MOSI stays aligned with SCLK.
- Requirements on the master side:
  - f_clk >= 4 × f_SCLK.
  - SS_n setup to the first SCLK rise >= 2 SCLK half-periods.
  - SS_n hold after the last SCLK fall >= 4 clk.
  - SS_n high between frames >= 4 clk.
- MISO:
  - First bit is valid 3 clk after the SS_n fall.
  - Each later bit is valid 3 clk after the SCLK fall that advances it.
- Execution:
  - The mem write or rd_buf load happens in the DECODE cycle, 3 clk after the SS_n rise.
  - frame_done or frame_err is asserted in that same cycle.
- A write and a read of the same address in back-to-back frames are ordered. The write commits in DECODE, before the next SS_n fall can be detected.
- Reset mid-frame: all state returns to reset values. The partial frame produces no pulse and no write, and the next complete frame is served normally.

## Structure
- Shared package eeprom_spi_pkg holds:
  - typedef enum logic [1:0] {EEP_READ=2'b00, EEP_WRITE=2'b01} eep_op_t
  - FRAME_BITS = 16
  - the state enum {WAIT_HI, IDLE, SHIFT, DECODE}
- The dispatcher's SPI master imports the same opcode enum.
- Sub-module spi_pin_sync: synchronizer plus rise/fall pulse generation. It is instantiated three times, once each for SS_n, SCLK and MOSI.
- mem is a register array with synchronous reset, not an inferred RAM.

## Test plan
- Write, then read back:
  - Frame 16'h6A5C → mem[0x2A] = 8'h5C and frame_done pulses once.
  - Then frame 16'h2A00, then dummy frame 16'h0000 → MISO shifts 16'h005C during the dummy frame.
- After reset, read addr 0x3F plus a dummy frame → 16'h0000 returned, and frame_err never asserts.
- Pipelined read:
  - Setup: mem[0x10] = 8'h11.
  - Stimulus: frame 16'h1000, then frame 16'h5022 (write 0x22 to 0x10), then 16'h1000, then 16'h0000.
  - Response: the three frames after the first read return 0x0011, 0x0011 and 0x0022.
- Short and long frames: 12 SCLK and 17 SCLK with write opcode → frame_err pulses each time, and mem and rd_buf are unchanged.
- Reserved opcode: frame 16'hBF77 → frame_done pulses, and mem and rd_buf are unchanged.
- Reset mid-frame:
  - Stimulus: assert rst_n low for 1 clk after 8 bits of 16'h4155, with SS_n held low; finish the 8 remaining bits; raise SS_n.
  - Response: no pulse and mem[0x01] = 0. The next full 16'h4155 writes 0x55.
